// File: rtl/gpr_arb_pkg.sv
// Shared constants and types for the GPR write-port arbiter.
// Optional feature macro: GPR_WR_ARB_RR_EN (round-robin instead of fixed priority).
package gpr_arb_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;

  // Requester indices
  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  // Register 0 is hardwired to zero; writes to it are dropped
  localparam logic [GPR_ADDR_W-1:0] GPR_ZERO = 5'd0;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] num;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic for the GPR write port.
// With GPR_WR_ARB_RR_EN defined, contention is resolved against last_grant_i
// (the requester that did not win last time wins). Otherwise requester 0
// always wins and last_grant_i is ignored.
module rr_arb2
  import gpr_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

`ifndef GPR_WR_ARB_RR_EN
  // last_grant only matters for round-robin; tie it off in fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // One-hot (or zero) grant; no grant while the port is disabled
  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11: begin
`ifdef GPR_WR_ARB_RR_EN
          grant_o = (last_grant_i == REQ_LOAD) ? 2'b01 : 2'b10;
`else
          grant_o = 2'b01;
`endif
        end
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Arbitrates the ALU (req0) and load (req1) writeback paths onto the single
// register-file write port. Outputs to the register file are registered;
// writes addressed to r0 are accepted but never strobed.
// Optional feature macro: GPR_WR_ARB_RR_EN (round-robin; default is fixed priority).
//
// Handshake: reqN_ready is combinational from reqN_valid, wr_enable and
// last_grant; a transfer occurs on the rising edge where reqN_valid &&
// reqN_ready. Requesters hold num/data stable while valid && !ready and may
// withdraw valid before being granted.
module gpr_wr_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_enable,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_num,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_num,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] num_write,
  output logic [DATA_W-1:0] data_write,
  output logic              last_grant
);

  logic [1:0]        grant;
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] sel_num;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] num_write_q,  num_write_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;
  logic              last_grant_q, last_grant_d;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .enable_i     (wr_enable),
    .grant_o      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign sel        = grant[1];
  assign sel_num    = sel ? req1_num  : req0_num;
  assign sel_data   = sel ? req1_data : req0_data;

  // Next state of the output stage and grant history
  always_comb begin
    reg_write_d  = 1'b0;
    num_write_d  = num_write_q;
    data_write_d = data_write_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      reg_write_d  = (sel_num != ADDR_W'(GPR_ZERO));
      num_write_d  = sel_num;
      data_write_d = sel_data;
      last_grant_d = sel;
    end
  end

  // Output registers; reset drops any staged write immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q  <= 1'b0;
      num_write_q  <= '0;
      data_write_q <= '0;
      last_grant_q <= REQ_LOAD;
    end else begin
      reg_write_q  <= reg_write_d;
      num_write_q  <= num_write_d;
      data_write_q <= data_write_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign num_write  = num_write_q;
  assign data_write = data_write_q;
  assign last_grant = last_grant_q;

endmodule
